// File: rtl/board_reset_seq.sv
// Board reset sequencer: PCIe npor + PLL lock hold, memory calibration wait, run/fault status LEDs.
// Latency: 2-cycle input synchronizers, outputs registered from next state; no backpressure (free-running).
module board_reset_seq #(
  parameter int         HOLD_CYCLES = 1024,
  parameter int         CAL_TIMEOUT = 16777216,
  parameter logic [5:0] MEM_MASK    = 6'h3F,
  parameter int         HB_DIV      = 25000000
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       pcie_npor_n,
  input  logic       pll_locked,
  input  logic [5:0] cal_success,
  input  logic [5:0] cal_fail,
  output logic       global_reset_n,
  output logic       kernel_reset_n,
  output logic [7:0] leds,
  output logic [2:0] state
);

  localparam int MAX_HC  = (HOLD_CYCLES > CAL_TIMEOUT) ? HOLD_CYCLES : CAL_TIMEOUT;
  localparam int MAX_ALL = (MAX_HC > HB_DIV) ? MAX_HC : HB_DIV;
  localparam int CNT_W   = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAL_LAST  = CNT_W'(CAL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HB_LAST   = CNT_W'(HB_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_NPOR = 3'd1,
    ST_HOLD      = 3'd2,
    ST_WAIT_CAL  = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } st_t;

  logic [13:0]      sync_q1;
  logic [13:0]      sync_q2;
  logic             npor_s;
  logic             locked_s;
  logic [5:0]       succ_s;
  logic [5:0]       fail_s;
  logic             link_ok;
  logic             mem_fail;
  logic             mem_ok;

  st_t              cur_st;
  st_t              st_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] hb_cnt;
  logic [CNT_W-1:0] hb_cnt_nxt;
  logic             hb_nxt;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {pcie_npor_n, pll_locked, cal_success, cal_fail};
      sync_q2 <= sync_q1;
    end
  end

  assign npor_s   = sync_q2[13];
  assign locked_s = sync_q2[12];
  assign succ_s   = sync_q2[11:6];
  assign fail_s   = sync_q2[5:0];
  assign link_ok  = npor_s & locked_s;
  assign mem_fail = |(fail_s & MEM_MASK);
  assign mem_ok   = ((succ_s & MEM_MASK) == MEM_MASK);

  // Link loss outranks every other exit from WAIT_CAL and RUN.
  always_comb begin
    st_nxt  = cur_st;
    cnt_nxt = '0;
    case (cur_st)
      ST_RESET:     st_nxt = ST_WAIT_NPOR;
      ST_WAIT_NPOR: if (link_ok) st_nxt = ST_HOLD;
      ST_HOLD: begin
        if (!link_ok)              st_nxt = ST_WAIT_NPOR;
        else if (cnt == HOLD_LAST) st_nxt = ST_WAIT_CAL;
        else                       cnt_nxt = cnt + CNT_ONE;
      end
      ST_WAIT_CAL: begin
        if (!link_ok)             st_nxt = ST_WAIT_NPOR;
        else if (mem_fail)        st_nxt = ST_FAULT;
        else if (mem_ok)          st_nxt = ST_RUN;
        else if (cnt == CAL_LAST) st_nxt = ST_FAULT;
        else                      cnt_nxt = cnt + CNT_ONE;
      end
      ST_RUN: begin
        if (!link_ok)      st_nxt = ST_WAIT_NPOR;
        else if (mem_fail) st_nxt = ST_FAULT;
      end
      ST_FAULT:     if (!npor_s) st_nxt = ST_WAIT_NPOR;
      default:      st_nxt = ST_RESET;
    endcase
  end

  // Heartbeat restarts low on every RUN entry; leds[6] doubles as its state bit.
  always_comb begin
    hb_cnt_nxt = '0;
    hb_nxt     = 1'b0;
    if (st_nxt == ST_RUN && cur_st == ST_RUN) begin
      if (hb_cnt == HB_LAST) begin
        hb_nxt = ~leds[6];
      end else begin
        hb_cnt_nxt = hb_cnt + CNT_ONE;
        hb_nxt     = leds[6];
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cur_st         <= ST_RESET;
      cnt            <= '0;
      hb_cnt         <= '0;
      global_reset_n <= 1'b0;
      kernel_reset_n <= 1'b0;
      leds           <= '0;
    end else begin
      cur_st         <= st_nxt;
      cnt            <= cnt_nxt;
      hb_cnt         <= hb_cnt_nxt;
      global_reset_n <= (st_nxt inside {ST_WAIT_CAL, ST_RUN, ST_FAULT});
      kernel_reset_n <= (st_nxt == ST_RUN);
      leds[7]        <= (st_nxt == ST_FAULT);
      leds[6]        <= hb_nxt;
      leds[5:0]      <= (st_nxt == ST_RESET) ? 6'h00 : (succ_s & MEM_MASK);
    end
  end

  assign state = cur_st;

endmodule

// File: tb/tb_board_reset_seq.sv
// Directed bench for board_reset_seq with short hold/timeout/heartbeat parameters.
module tb_board_reset_seq;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic       pcie_npor_n;
  logic       pll_locked;
  logic [5:0] cal_success;
  logic [5:0] cal_fail;
  logic       global_reset_n;
  logic       kernel_reset_n;
  logic [7:0] leds;
  logic [2:0] state;

  board_reset_seq #(
    .HOLD_CYCLES (8),
    .CAL_TIMEOUT (32),
    .MEM_MASK    (6'h3F),
    .HB_DIV      (4)
  ) dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .pcie_npor_n    (pcie_npor_n),
    .pll_locked     (pll_locked),
    .cal_success    (cal_success),
    .cal_fail       (cal_fail),
    .global_reset_n (global_reset_n),
    .kernel_reset_n (kernel_reset_n),
    .leds           (leds),
    .state          (state)
  );

  always #5 clk_clk = ~clk_clk;

  // One record: at cycle cyc, check the outputs, then drive the inputs (held until the next record).
  typedef struct {
    int cyc;
    int rst, npor, lock, succ, fail;
    int grst, krst, led, st;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc;
  int   n;

  function automatic void add(int c, int r, int np, int lk, int s, int f,
                              int g, int k, int l, int st);
    vec_t v;
    v.cyc = c; v.rst = r; v.npor = np; v.lock = lk; v.succ = s; v.fail = f;
    v.grst = g; v.krst = k; v.led = l; v.st = st;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(negedge clk_clk);
    cyc++;
  endtask

  task automatic drive(input int r, input int np, input int lk, input int s, input int f);
    reset_reset = (r != 0);
    pcie_npor_n = (np != 0);
    pll_locked  = (lk != 0);
    cal_success = 6'(s);
    cal_fail    = 6'(f);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int g, input int k, input int l, input int st);
    chk({tag, "_grst"},  32'(global_reset_n), g);
    chk({tag, "_krst"},  32'(kernel_reset_n), k);
    chk({tag, "_leds"},  32'(leds), l);
    chk({tag, "_state"}, 32'(state), st);
  endtask

  initial begin
    //   cyc rst np lk succ  fail  grst krst leds  st
    // power-up with link present, success arrives in cycle 20, then heartbeat
    add(  0, 0, 1, 1, 'h00, 'h00,  0, 0, 'h00, 0);
    add(  1, 0, 1, 1, 'h00, 'h00,  0, 0, 'h00, 1);
    add(  2, 0, 1, 1, 'h00, 'h00,  0, 0, 'h00, 1);
    add(  3, 0, 1, 1, 'h00, 'h00,  0, 0, 'h00, 2);
    add( 10, 0, 1, 1, 'h00, 'h00,  0, 0, 'h00, 2);
    add( 11, 0, 1, 1, 'h00, 'h00,  1, 0, 'h00, 3);
    add( 20, 0, 1, 1, 'h3F, 'h00,  1, 0, 'h00, 3);
    add( 22, 0, 1, 1, 'h3F, 'h00,  1, 0, 'h00, 3);
    add( 23, 0, 1, 1, 'h3F, 'h00,  1, 1, 'h3F, 4);
    add( 26, 0, 1, 1, 'h3F, 'h00,  1, 1, 'h3F, 4);
    add( 27, 0, 1, 1, 'h3F, 'h00,  1, 1, 'h7F, 4);
    add( 31, 0, 1, 1, 'h3F, 'h00,  1, 1, 'h3F, 4);
    add( 35, 0, 1, 1, 'h3F, 'h00,  1, 1, 'h7F, 4);
    // one-cycle reset pulse in RUN, then full resequence
    add( 36, 1, 1, 1, 'h3F, 'h00,  1, 1, 'h7F, 4);
    add( 37, 0, 1, 1, 'h3F, 'h00,  0, 0, 'h00, 0);
    add( 38, 0, 1, 1, 'h3F, 'h00,  0, 0, 'h00, 1);
    add( 39, 0, 1, 1, 'h3F, 'h00,  0, 0, 'h00, 1);
    add( 40, 0, 1, 1, 'h3F, 'h00,  0, 0, 'h3F, 2);
    add( 47, 0, 1, 1, 'h3F, 'h00,  0, 0, 'h3F, 2);
    add( 48, 0, 1, 1, 'h3F, 'h00,  1, 0, 'h3F, 3);
    add( 49, 0, 1, 1, 'h3F, 'h00,  1, 1, 'h3F, 4);
    add( 53, 0, 1, 1, 'h3F, 'h00,  1, 1, 'h7F, 4);
    // npor loss together with cal_fail[0] in RUN: link loss wins
    add( 54, 0, 0, 1, 'h3F, 'h01,  1, 1, 'h7F, 4);
    add( 56, 0, 0, 1, 'h3F, 'h01,  1, 1, 'h7F, 4);
    add( 57, 0, 1, 1, 'h00, 'h00,  0, 0, 'h3F, 1);
    add( 59, 0, 1, 1, 'h00, 'h00,  0, 0, 'h3F, 1);
    add( 60, 0, 1, 1, 'h00, 'h00,  0, 0, 'h00, 2);
    // one-cycle lock glitch seen at hold count 5: hold restarts from zero
    add( 63, 0, 1, 0, 'h00, 'h00,  0, 0, 'h00, 2);
    add( 64, 0, 1, 1, 'h00, 'h00,  0, 0, 'h00, 2);
    add( 65, 0, 1, 1, 'h00, 'h00,  0, 0, 'h00, 2);
    add( 66, 0, 1, 1, 'h00, 'h00,  0, 0, 'h00, 1);
    add( 67, 0, 1, 1, 'h00, 'h00,  0, 0, 'h00, 2);
    add( 74, 0, 1, 1, 'h00, 'h00,  0, 0, 'h00, 2);
    add( 75, 0, 1, 1, 'h1F, 'h00,  1, 0, 'h00, 3);

    cyc = -3;
    drive(1, 1, 1, 0, 0);
    repeat (3) tick();

    foreach (vecs[i]) begin
      n = 0;
      while (cyc < vecs[i].cyc && n < 100) begin
        tick();
        n++;
      end
      chk_all($sformatf("v%0d", i), vecs[i].grst, vecs[i].krst, vecs[i].led, vecs[i].st);
      drive(vecs[i].rst, vecs[i].npor, vecs[i].lock, vecs[i].succ, vecs[i].fail);
    end

    // Partial calibration (ddr3a..qdriic only) times out after 32 WAIT_CAL cycles
    n = 0;
    while (state == 3'd3 && n < 40) begin
      tick();
      n++;
      if (state == 3'd3) chk("cal_wait_krst", 32'(kernel_reset_n), 0);
    end
    chk("cal_timeout_cycles", n, 32);
    chk_all("timeout_fault", 1, 0, 'h9F, 5);

    // FAULT ignores lock loss, leaves only on npor loss
    drive(0, 1, 0, 'h1F, 0);
    repeat (5) tick();
    chk("fault_sticky_lock", 32'(state), 5);
    drive(0, 0, 0, 'h1F, 0);
    repeat (2) tick();
    chk("fault_npor_lat", 32'(state), 5);
    tick();
    chk_all("fault_exit", 0, 0, 'h1F, 1);

    // Fail and full success together in WAIT_CAL: fail wins
    drive(0, 1, 1, 0, 0);
    n = 0;
    while (state != 3'd3 && n < 20) begin
      tick();
      n++;
    end
    chk("reach_wait_cal_cycles", n, 11);
    chk_all("wait_cal2", 1, 0, 'h00, 3);
    drive(0, 1, 1, 'h3F, 'h04);
    repeat (2) tick();
    chk("fail_vs_succ_lat", 32'(state), 3);
    tick();
    chk_all("fail_over_succ", 1, 0, 'hBF, 5);

    // Reset asserted mid-HOLD, then normal resequence to RUN
    drive(0, 0, 1, 'h3F, 0);
    repeat (3) tick();
    chk("npor_drop_state", 32'(state), 1);
    drive(0, 1, 1, 'h3F, 0);
    repeat (3) tick();
    chk("rehold_state", 32'(state), 2);
    repeat (2) tick();
    drive(1, 1, 1, 'h3F, 0);
    tick();
    chk_all("reset_mid_hold", 0, 0, 'h00, 0);
    drive(0, 1, 1, 'h3F, 0);
    tick();
    chk("post_reset_state", 32'(state), 1);
    n = 0;
    while (state != 3'd4 && n < 30) begin
      tick();
      if (state != 3'd4) chk("reseq_krst_low", 32'(kernel_reset_n), 0);
      n++;
    end
    chk("reseq_run_cycles", n, 11);
    chk_all("reseq_run", 1, 1, 'h3F, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
